// File: rtl/dram_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// dram_run_ctrl_if
//   Bundles the controller's handshake and bus signals: the host load
//   stream, the dump output stream, the processor bus and the single DRAM
//   port.
//
//   master : the run controller (drives load_ready, dump_*, cpu_rst, dram_*)
//   slave  : the surroundings (host, sink, processor, DRAM)
//
//   load_valid/load_data/load_ready   host byte stream into LOAD
//   dump_valid/dump_data/dump_ready   output byte stream from DUMP
//   cpu_rst/cpu_pc/cpu_addr/cpu_wdata/cpu_we  processor control and bus
//   dram_addr/dram_wdata/dram_we/dram_rdata   DRAM port (read data is
//                                             valid one cycle after addr)
// ---------------------------------------------------------------------------
interface dram_run_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;

    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic              dump_ready;

    logic              cpu_rst;
    logic [7:0]        cpu_pc;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;

    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic              dram_we;
    logic [DATA_W-1:0] dram_rdata;

    modport master (
        input  load_valid, load_data, dump_ready,
        input  cpu_pc, cpu_addr, cpu_wdata, cpu_we, dram_rdata,
        output load_ready, dump_valid, dump_data,
        output cpu_rst, dram_addr, dram_wdata, dram_we
    );

    modport slave (
        output load_valid, load_data, dump_ready,
        output cpu_pc, cpu_addr, cpu_wdata, cpu_we, dram_rdata,
        input  load_ready, dump_valid, dump_data,
        input  cpu_rst, dram_addr, dram_wdata, dram_we
    );
endinterface

// File: rtl/dram_run_ctrl.sv
// ---------------------------------------------------------------------------
// dram_run_ctrl
//   Run sequencer owning the single DRAM port. A start pulse loads an image
//   from the host stream into DRAM[0..IMG_WORDS-1], releases the processor
//   until it reaches END_PC (or RUN_TMO cycles elapse), then streams
//   DRAM[OUT_BASE..OUT_BASE+OUT_WORDS-1] out. The processor is held in reset
//   outside RUN.
//
//   clk      system clock
//   rst      synchronous, active-high reset
//   start_i  begin a LOAD (honoured only in IDLE/DONE)
//   bus      handshake and bus bundle (see dram_run_ctrl_if)
//   busy_o   state is LOAD, RUN or DUMP
//   done_o   state is DONE
//   err_o    sticky RUN timeout flag, cleared by rst or an accepted start
// ---------------------------------------------------------------------------
module dram_run_ctrl #(
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 8,
    parameter int          IMG_WORDS = 65536,
    parameter int          OUT_BASE  = 1,
    parameter int          OUT_WORDS = 16384,
    parameter logic [7:0]  END_PC    = 8'd120,
    parameter logic [23:0] RUN_TMO   = 24'hFFFFFF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    dram_run_ctrl_if.master bus,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);
    // One spare bit so the counter can hold IMG_WORDS / OUT_WORDS == 2^ADDR_W
    // limits without wrapping.
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  IMG_LAST = CNT_W'(IMG_WORDS - 1);
    localparam logic [CNT_W-1:0]  OUT_LAST = CNT_W'(OUT_WORDS - 1);
    localparam logic [ADDR_W-1:0] OUT_BA   = ADDR_W'(OUT_BASE);
    localparam logic [23:0]       RUN_LAST = RUN_TMO - 24'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       run_cnt_q, run_cnt_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    // High for the first DUMP_OUT cycle, when dram_rdata carries the byte
    // addressed in DUMP_RD; afterwards the captured copy is presented.
    logic              first_q, first_d;
    logic [ADDR_W-1:0] dump_addr;

    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    assign dump_addr = OUT_BA + cnt_q[ADDR_W-1:0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        cnt_d          = cnt_q;
        run_cnt_d      = run_cnt_q;
        cpu_rst_d      = 1'b1;
        err_d          = err_q;
        hold_d         = hold_q;
        first_d        = 1'b0;
        bus.load_ready = 1'b0;
        bus.dump_valid = 1'b0;
        bus.dump_data  = hold_q;
        bus.dram_addr  = '0;
        bus.dram_wdata = '0;
        bus.dram_we    = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end

            S_LOAD: begin
                bus.load_ready = 1'b1;
                bus.dram_addr  = cnt_q[ADDR_W-1:0];
                if (bus.load_valid) begin
                    bus.dram_wdata = bus.load_data;
                    bus.dram_we    = 1'b1;
                    if (cnt_q == IMG_LAST) begin
                        state_d   = S_RUN;
                        cnt_d     = '0;
                        run_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_RUN: begin
                bus.dram_addr  = bus.cpu_addr;
                bus.dram_wdata = bus.cpu_wdata;
                bus.dram_we    = bus.cpu_we;
                if (bus.cpu_pc == END_PC) begin
                    state_d = S_DUMP_RD;
                    cnt_d   = '0;
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    // cpu_rst_q is still high in the entry cycle and drops
                    // one cycle later.
                    run_cnt_d = run_cnt_q + 24'd1;
                    cpu_rst_d = 1'b0;
                end
            end

            S_DUMP_RD: begin
                bus.dram_addr = dump_addr;
                state_d       = S_DUMP_OUT;
                first_d       = 1'b1;
            end

            S_DUMP_OUT: begin
                // Keep the read address steady while waiting on the sink.
                bus.dram_addr  = dump_addr;
                bus.dump_valid = 1'b1;
                if (first_q) begin
                    bus.dump_data = bus.dram_rdata;
                    hold_d        = bus.dram_rdata;
                end
                if (bus.dump_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == OUT_LAST) ? S_DONE : S_DUMP_RD;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them
        // update together from the values computed in this cycle.
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            run_cnt_q <= '0;
            cpu_rst_q <= 1'b1;
            err_q     <= 1'b0;
            hold_q    <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_cnt_q <= run_cnt_d;
            cpu_rst_q <= cpu_rst_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            first_q   <= first_d;
        end
    end

    assign bus.cpu_rst = cpu_rst_q;
    assign busy_o      = (state_q == S_LOAD) || (state_q == S_RUN) ||
                         (state_q == S_DUMP_RD) || (state_q == S_DUMP_OUT);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
endmodule

// File: tb/tb_dram_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dram_run_ctrl
//   Drives the run controller with a reduced configuration (8-bit DRAM
//   address, full 256-word image, 256-word dump that wraps from 0xFF to 0x00,
//   100-cycle RUN timeout). A byte-array DRAM sits on the port; a phase-level
//   reference model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_dram_run_ctrl;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int IMG = 256;
    localparam int OB  = 1;
    localparam int OW  = 256;
    localparam int EPC = 120;
    localparam int TMO = 100;
    localparam int MEM = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, err;

    dram_run_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dram_run_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .IMG_WORDS(IMG), .OUT_BASE(OB),
        .OUT_WORDS(OW), .END_PC(8'(EPC)), .RUN_TMO(24'(TMO))
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .bus(bus),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // DRAM: synchronous write, read data one cycle after the address.
    logic [DW-1:0] dram [MEM];
    int we_pulses = 0;
    always @(posedge clk) begin
        if (bus.dram_we === 1'b1) begin
            dram[bus.dram_addr] <= bus.dram_wdata;
            we_pulses <= we_pulses + 1;
        end
        bus.dram_rdata <= dram[bus.dram_addr];
    end

    // Reference model: phase, progress index, RUN cycles elapsed, error flag
    // and the memory image the model believes DRAM should hold.
    typedef enum {P_IDLE, P_LOAD, P_RUN, P_RD, P_OUT, P_DONE} phase_t;
    phase_t        m_phase = P_IDLE;
    int            m_idx   = 0;
    int            m_run   = 0;
    bit            m_err   = 1'b0;
    logic [DW-1:0] ref_mem [MEM];

    always @(negedge clk) begin
        int ea;
        #1;
        check("busy", 32'(busy), (m_phase inside {P_LOAD, P_RUN, P_RD, P_OUT}) ? 1 : 0);
        check("done", 32'(done), (m_phase == P_DONE) ? 1 : 0);
        check("err", 32'(err), 32'(m_err));
        check("cpu_rst", 32'(bus.cpu_rst), (m_phase == P_RUN && m_run > 0) ? 0 : 1);
        check("load_ready", 32'(bus.load_ready), (m_phase == P_LOAD) ? 1 : 0);
        check("dump_valid", 32'(bus.dump_valid), (m_phase == P_OUT) ? 1 : 0);
        ea = (OB + m_idx) % MEM;
        case (m_phase)
            P_IDLE, P_DONE: begin
                check("idle_we", 32'(bus.dram_we), 0);
                check("idle_addr", 32'(bus.dram_addr), 0);
            end
            P_LOAD: begin
                check("load_we", 32'(bus.dram_we), 32'(bus.load_valid));
                if (bus.load_valid) begin
                    check("load_addr", 32'(bus.dram_addr), m_idx);
                    check("load_wdata", 32'(bus.dram_wdata), 32'(bus.load_data));
                    ref_mem[m_idx] = bus.load_data;
                end
            end
            P_RUN: begin
                check("run_we", 32'(bus.dram_we), 32'(bus.cpu_we));
                check("run_addr", 32'(bus.dram_addr), 32'(bus.cpu_addr));
                if (bus.cpu_we) begin
                    check("run_wdata", 32'(bus.dram_wdata), 32'(bus.cpu_wdata));
                    ref_mem[bus.cpu_addr] = bus.cpu_wdata;
                end
            end
            P_RD: begin
                check("rd_we", 32'(bus.dram_we), 0);
                check("rd_addr", 32'(bus.dram_addr), ea);
            end
            P_OUT: begin
                check("out_we", 32'(bus.dram_we), 0);
                check("dump_data", 32'(bus.dump_data), 32'(ref_mem[ea]));
            end
            default: ;
        endcase

        if (rst) begin
            m_phase = P_IDLE; m_idx = 0; m_run = 0; m_err = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE:
                    if (start) begin m_phase = P_LOAD; m_idx = 0; m_err = 1'b0; end
                P_LOAD:
                    if (bus.load_valid) begin
                        if (m_idx == IMG - 1) begin m_phase = P_RUN; m_idx = 0; m_run = 0; end
                        else m_idx++;
                    end
                P_RUN:
                    if (int'(bus.cpu_pc) == EPC) begin m_phase = P_RD; m_idx = 0; end
                    else if (m_run + 1 == TMO) begin m_phase = P_DONE; m_err = 1'b1; end
                    else m_run++;
                P_RD: m_phase = P_OUT;
                P_OUT:
                    if (bus.dump_ready) begin
                        m_idx++;
                        m_phase = (m_idx == OW) ? P_DONE : P_RD;
                    end
                default: ;
            endcase
        end
    end

    logic [DW-1:0] img [IMG];

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Streams n bytes (random gaps if asked) with noise on start and the
    // CPU bus; returns on the negedge after the last accepted byte.
    task automatic load_bytes(input int n, input bit gaps);
        int k = 0;
        for (int g = 0; g < 8 * n + 16 && k < n; g++) begin
            @(negedge clk);
            bus.load_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
            bus.load_data  = 8'($urandom);
            start          = ($urandom_range(15) == 0);
            bus.cpu_pc     = 8'($urandom);
            bus.cpu_we     = 1'($urandom);
            bus.cpu_addr   = 8'($urandom);
            bus.cpu_wdata  = 8'($urandom);
            #1;
            if (bus.load_valid && bus.load_ready) begin
                img[k] = bus.load_data;
                k++;
            end
        end
        check("load_count", k, n);
        @(negedge clk);
        bus.load_valid = 1'b0; start = 1'b0;
        bus.cpu_pc = 8'd0; bus.cpu_we = 1'b0;
    endtask

    initial begin
        int accepted;
        int run_n;
        rst = 1'b1; start = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.dump_ready = 1'b0;
        bus.cpu_pc = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 1'b0;
        for (int i = 0; i < MEM; i++) begin
            dram[i]    = 8'(i ^ 8'hC3);
            ref_mem[i] = 8'(i ^ 8'hC3);
        end

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        check("rst_cpu_rst", 32'(bus.cpu_rst), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dram_we", 32'(bus.dram_we), 0);
        check("rst_load_ready", 32'(bus.load_ready), 0);
        @(negedge clk); rst = 1'b0;

        // Partial LOAD of 37 bytes, then reset: DRAM keeps what was written.
        pulse_start();
        load_bytes(37, 1'b1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_load_ready", 32'(bus.load_ready), 0);
        for (int i = 0; i < 37; i++) check("abort_keep", 32'(dram[i]), 32'(img[i]));
        check("abort_untouched", 32'(dram[37]), 32'(8'(37 ^ 8'hC3)));

        // Full LOAD with gaps; RUN starts the cycle after the last byte.
        pulse_start();
        we_pulses = 0;
        load_bytes(IMG, 1'b1);
        #1;
        check("load_we_pulses", we_pulses, IMG);
        check("run_entry_busy", 32'(busy), 1);
        check("run_entry_cpu_rst", 32'(bus.cpu_rst), 1);
        for (int i = 0; i < IMG; i += 51) check("load_image", 32'(dram[i]), 32'(img[i]));
        @(negedge clk);
        #1;
        check("run_cpu_rst_low", 32'(bus.cpu_rst), 0);

        // CPU stores, ending with 0x5A to address 1, then halts.
        repeat (5) begin
            @(negedge clk);
            bus.cpu_we = 1'($urandom); bus.cpu_addr = 8'($urandom); bus.cpu_wdata = 8'($urandom);
        end
        @(negedge clk); bus.cpu_we = 1'b1; bus.cpu_addr = 8'h01; bus.cpu_wdata = 8'h5A;
        #1;
        check("run_we_mirror", 32'(bus.dram_we), 1);
        @(negedge clk); bus.cpu_we = 1'b0; bus.cpu_pc = 8'(EPC);
        @(negedge clk); bus.cpu_pc = 8'd0;
        #1;
        check("halt_cpu_rst", 32'(bus.cpu_rst), 1);
        check("halt_rd_addr", 32'(bus.dram_addr), 32'h01);
        check("halt_dump_valid", 32'(bus.dump_valid), 0);

        // First byte held while the sink stalls for 5 cycles.
        accepted = 0;
        repeat (5) begin
            @(negedge clk); bus.dump_ready = 1'b0;
            #1;
            check("stall_valid", 32'(bus.dump_valid), 1);
            check("stall_data", 32'(bus.dump_data), 32'h5A);
        end
        @(negedge clk); bus.dump_ready = 1'b1;
        #1;
        check("first_data", 32'(bus.dump_data), 32'h5A);
        if (bus.dump_valid && bus.dump_ready) accepted++;

        // Rest of the dump with random backpressure; start must be ignored.
        for (int g = 0; g < 8 * OW; g++) begin
            @(negedge clk);
            bus.dump_ready = 1'($urandom);
            start = !done && ($urandom_range(7) == 0);
            #1;
            if (bus.dump_valid && bus.dump_ready) accepted++;
            if (done) break;
        end
        check("dump_count", accepted, OW);
        check("dump_done", 32'(done), 1);
        check("dump_err", 32'(err), 0);

        // Start from DONE re-enters LOAD.
        bus.dump_ready = 1'b0;
        pulse_start();
        #1;
        check("restart_busy", 32'(busy), 1);
        check("restart_load_ready", 32'(bus.load_ready), 1);

        // RUN that never halts: timeout after exactly TMO RUN cycles.
        load_bytes(IMG, 1'b0);
        run_n = 1;
        for (int g = 0; g < 4 * TMO; g++) begin
            @(negedge clk);
            bus.cpu_pc = 8'($urandom_range(EPC - 1));
            bus.cpu_we = 1'($urandom); bus.cpu_addr = 8'($urandom); bus.cpu_wdata = 8'($urandom);
            #1;
            if (!busy) break;
            run_n++;
        end
        bus.cpu_we = 1'b0; bus.cpu_pc = 8'd0;
        check("tmo_cycles", run_n, TMO);
        check("tmo_err", 32'(err), 1);
        check("tmo_done", 32'(done), 1);

        // An accepted start clears the sticky error.
        pulse_start();
        #1;
        check("start_clears_err", 32'(err), 0);

        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
